// File: rtl/agnus_blitter_pkg.sv
// Shared types and constants for the blitter source-channel front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agnus_blitter_pkg;

    localparam int WIDTH_BITS  = 6;
    localparam int HEIGHT_BITS = 10;

    localparam logic [15:0] FULL_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Registered bundle handed to the barrel shifter.
    typedef struct packed {
        logic [15:0] new_val;
        logic [15:0] old_val;
        logic [3:0]  shift;
        logic        desc;
    } bundle_t;

    // A zero width means 64 words: the extra top bit carries that case.
    function automatic logic [WIDTH_BITS:0] load_width(input logic [WIDTH_BITS-1:0] w);
        return {(w == '0), w};
    endfunction

    // A zero height means 1024 lines.
    function automatic logic [HEIGHT_BITS:0] load_height(input logic [HEIGHT_BITS-1:0] h);
        return {(h == '0), h};
    endfunction

endpackage

// File: rtl/agnus_blitter_linecount.sv
// Word/line position tracker: flags first word, last word and last line of a blit.
// Latency: flags are combinational from the counters; counters move on the enabled edge of a step.
// Backpressure: none of its own; advances only when the parent steps it.
module agnus_blitter_linecount
    import agnus_blitter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clk7_en,
    input  logic                   load,
    input  logic                   step,
    input  logic [WIDTH_BITS-1:0]  width,
    input  logic [HEIGHT_BITS-1:0] height,
    output logic                   first_word,
    output logic                   last_word,
    output logic                   last_line
);

    logic [WIDTH_BITS:0]  wlen;
    logic [WIDTH_BITS:0]  wcnt;
    logic [HEIGHT_BITS:0] lcnt;

    // wcnt counts words left in the current line (including the one at the head);
    // it reloads from the latched width when the last word of a line is taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wlen <= '0;
            wcnt <= '0;
            lcnt <= '0;
        end else if (clk7_en) begin
            if (load) begin
                wlen <= load_width(width);
                wcnt <= load_width(width);
                lcnt <= load_height(height);
            end else if (step) begin
                if (last_word) begin
                    wcnt <= wlen;
                    lcnt <= lcnt - {{HEIGHT_BITS{1'b0}}, 1'b1};
                end else begin
                    wcnt <= wcnt - {{WIDTH_BITS{1'b0}}, 1'b1};
                end
            end
        end
    end

    assign first_word = (wcnt == wlen);
    assign last_word  = (wcnt == {{WIDTH_BITS{1'b0}}, 1'b1});
    assign last_line  = (lcnt == {{HEIGHT_BITS{1'b0}}, 1'b1});

endmodule

// File: rtl/agnus_blitter_srcpipe.sv
// Source-channel front end: masks DMA words at line edges and pairs them with the previous word.
// Latency: one enabled cycle from accept to bundle valid; one word per enabled cycle sustained.
// Backpressure: din_ready drops while a bundle is held unconsumed; outputs stay frozen meanwhile.
module agnus_blitter_srcpipe
    import agnus_blitter_pkg::*;
#(
    parameter bit MASKED = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clk7_en,
    input  logic                   start,
    input  logic                   desc_in,
    input  logic [3:0]             shift_in,
    input  logic [WIDTH_BITS-1:0]  width,
    input  logic [HEIGHT_BITS-1:0] height,
    input  logic [15:0]            fwm,
    input  logic [15:0]            lwm,
    input  logic [15:0]            din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [15:0]            new_val,
    output logic [15:0]            old_val,
    output logic [3:0]             shift,
    output logic                   desc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    state_t      state;
    state_t      state_nxt;
    bundle_t     bundle_q;
    logic [15:0] last_m;
    logic        out_valid_q;
    logic        done_q;

    logic        load;
    logic        accept;
    logic        drain_done;
    logic        first_word;
    logic        last_word;
    logic        last_line;
    logic [15:0] mask;
    logic [15:0] m;

    assign din_ready = (state == ST_RUN) && (!out_valid_q || out_ready);
    assign accept    = din_valid && din_ready && clk7_en;

    agnus_blitter_linecount u_linecount (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk7_en    (clk7_en),
        .load       (load),
        .step       (accept),
        .width      (width),
        .height     (height),
        .first_word (first_word),
        .last_word  (last_word),
        .last_line  (last_line)
    );

    // Edge mask: fwm and lwm combine naturally when a line is a single word.
    always_comb begin
        mask = FULL_MASK;
        if (MASKED) begin
            if (first_word) mask = mask & fwm;
            if (last_word)  mask = mask & lwm;
        end
    end

    assign m = din & mask;

    // Next-state logic: start only counts in IDLE, so starts mid-blit are dropped.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        drain_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_word && last_line) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    drain_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; clk7_en gates every transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else if (clk7_en) begin
            state <= state_nxt;
        end
    end

    // Bundle register: a simultaneous consume and accept reloads without a bubble.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bundle_q    <= '0;
            last_m      <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (clk7_en) begin
            done_q <= drain_done;
            if (load) begin
                bundle_q.shift <= shift_in;
                bundle_q.desc  <= desc_in;
                last_m         <= '0;
            end
            if (accept) begin
                bundle_q.new_val <= m;
                bundle_q.old_val <= last_m;
                last_m           <= m;
                out_valid_q      <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign new_val   = bundle_q.new_val;
    assign old_val   = bundle_q.old_val;
    assign shift     = bundle_q.shift;
    assign desc      = bundle_q.desc;
    assign out_valid = out_valid_q;
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;

endmodule
